// File: rtl/fetch_stage_pkg.sv
// Shared fetch-path types and the NOP encoding used to fill an empty IF/ID slot.
package fetch_stage_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;
  typedef logic        bool_t;
  typedef logic        clock_t;

  localparam instr_t NOP_ENCODING = 32'h0000_0013;
endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: clear wins over load; otherwise it holds its contents.
module if_id_register
  import fetch_stage_pkg::*;
#(
  parameter instr_t NOP_INSTR = NOP_ENCODING
) (
  input  clock_t clk,
  input  bool_t  reset,
  input  bool_t  load,
  input  bool_t  clear,
  input  addr_t  load_pc,
  input  instr_t load_instr,
  output bool_t  valid,
  output addr_t  pc,
  output instr_t instr
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-word skid buffer
// for decode back-pressure, and a drop flag to discard responses killed by a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter instr_t NOP_INSTR = NOP_ENCODING
) (
  input  clock_t clk,
  input  bool_t  reset,
  input  addr_t  pc,
  input  bool_t  flush,
  input  bool_t  decode_stall,
  output bool_t  imem_req_valid,
  output addr_t  imem_req_addr,
  input  bool_t  imem_req_ready,
  input  bool_t  imem_resp_valid,
  input  instr_t imem_resp_data,
  output bool_t  if_valid,
  output addr_t  if_pc,
  output instr_t if_instr,
  output bool_t  pc_stall
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  state_e state, state_next;
  bool_t  drop, drop_next;
  addr_t  req_pc;
  instr_t hold_word;

  bool_t  handshake;
  bool_t  load, clear, capture_hold;
  instr_t load_instr;

  assign imem_req_valid = (state == IDLE);
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid && imem_req_ready;
  assign pc_stall       = !handshake;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    drop_next    = drop;
    load         = 1'b0;
    capture_hold = 1'b0;
    load_instr   = imem_resp_data;

    unique case (state)
      IDLE: begin
        // A flush racing the handshake means the address just sent is stale.
        drop_next = handshake && flush;
        if (handshake) state_next = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_next = IDLE;
          drop_next  = 1'b0;
          if (!drop && !flush) begin
            if (!if_valid || !decode_stall) begin
              load = 1'b1;
            end else begin
              capture_hold = 1'b1;
              state_next   = HOLD;
            end
          end
        end else if (flush) begin
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_next = IDLE;
        end else if (!decode_stall) begin
          load       = 1'b1;
          load_instr = hold_word;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decode consumed the held word and nothing replaces it, or a redirect kills it.
  assign clear = flush || (if_valid && !decode_stall && !load);

  // NOTE: the skid buffer and request address are reset like any other
  // register so no stale word can leak out after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drop      <= 1'b0;
      req_pc    <= '0;
      hold_word <= NOP_INSTR;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (handshake)         req_pc    <= pc;
      if (capture_hold)      hold_word <= imem_resp_data;
      else if (flush)        hold_word <= NOP_INSTR;
    end
  end

  if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .clear      (clear),
    .load_pc    (req_pc),
    .load_instr (load_instr),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshake latency, back-pressure, flush/drop and reset cases.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam instr_t NOP = 32'h0000_0013;

  logic   clk = 1'b0;
  logic   reset;
  addr_t  pc;
  logic   flush, decode_stall;
  logic   imem_req_valid, imem_req_ready, imem_resp_valid;
  addr_t  imem_req_addr;
  instr_t imem_resp_data;
  logic   if_valid, pc_stall;
  addr_t  if_pc;
  instr_t if_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .flush           (flush),
    .decode_stall    (decode_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .pc_stall        (pc_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at addr and return data on the following cycle.
  task automatic fetch(input addr_t addr, input instr_t data);
    pc = addr;
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    cyc();
    imem_resp_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; pc = '0; flush = 1'b0; decode_stall = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    #12;
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("rst_pc_stall", 32'(pc_stall), 32'd1);
    @(negedge clk) reset = 1'b0;
    cyc();

    // Basic fetch with minimum latency.
    pc = 32'h0; imem_req_ready = 1'b1; #1;
    check("hs_pc_stall", 32'(pc_stall), 32'd0);
    check("hs_req_addr", imem_req_addr, 32'h0);
    cyc();
    #1;
    check("wait_req_valid", 32'(imem_req_valid), 32'd0);
    check("wait_pc_stall", 32'(pc_stall), 32'd1);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
    cyc();
    imem_resp_valid = 1'b0; #1;
    check("basic_if_valid", 32'(if_valid), 32'd1);
    check("basic_if_pc", if_pc, 32'h0);
    check("basic_if_instr", if_instr, 32'h0050_0093);

    // Memory not ready for three cycles; held word drains on the first edge.
    pc = 32'h4; imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("nrdy_pc_stall", 32'(pc_stall), 32'd1);
      check("nrdy_req_addr", imem_req_addr, 32'h4);
      check("nrdy_if_valid", 32'(if_valid), 32'd0);
    end

    // Decode back-pressure parks the new word in HOLD.
    fetch(32'h4, 32'h0040_0193);
    decode_stall = 1'b1; pc = 32'h8; imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h00A0_0113;
    cyc();
    imem_resp_valid = 1'b0; #1;
    check("hold_req_valid", 32'(imem_req_valid), 32'd0);
    check("hold_if_valid", 32'(if_valid), 32'd1);
    check("hold_if_pc", if_pc, 32'h4);
    check("hold_if_instr", if_instr, 32'h0040_0193);
    cyc();
    check("hold2_if_instr", if_instr, 32'h0040_0193);
    decode_stall = 1'b0;
    cyc();
    check("unhold_if_valid", 32'(if_valid), 32'd1);
    check("unhold_if_pc", if_pc, 32'h8);
    check("unhold_if_instr", if_instr, 32'h00A0_0113);
    check("unhold_req_valid", 32'(imem_req_valid), 32'd1);
    cyc();
    check("drain_if_valid", 32'(if_valid), 32'd0);

    // Flush while in HOLD discards both the held and buffered words.
    fetch(32'h10, 32'h0000_0213);
    decode_stall = 1'b1; pc = 32'h14; imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0293;
    cyc();
    imem_resp_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; decode_stall = 1'b0; #1;
    check("hflush_if_valid", 32'(if_valid), 32'd0);
    check("hflush_if_instr", if_instr, NOP);
    check("hflush_req_valid", 32'(imem_req_valid), 32'd1);
    cyc();
    check("hflush_no_buf", 32'(if_valid), 32'd0);

    // Flush in WAIT, late response dropped, redirected pc fetched next.
    pc = 32'hC; imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; flush = 1'b1; pc = 32'h100;
    cyc();
    flush = 1'b0;
    cyc();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    cyc();
    imem_resp_valid = 1'b0; #1;
    check("wflush_if_valid", 32'(if_valid), 32'd0);
    check("wflush_if_instr", if_instr, NOP);
    check("wflush_req_valid", 32'(imem_req_valid), 32'd1);
    check("wflush_req_addr", imem_req_addr, 32'h100);
    fetch(32'h100, 32'h0000_0513);
    check("redir_if_pc", if_pc, 32'h100);
    check("redir_if_instr", if_instr, 32'h0000_0513);

    // Flush coinciding with an IDLE handshake: returning word is stale.
    pc = 32'h104; imem_req_ready = 1'b1; flush = 1'b1; #1;
    check("ihs_pc_stall", 32'(pc_stall), 32'd0);
    cyc();
    flush = 1'b0; imem_req_ready = 1'b0; #1;
    check("ihs_if_valid", 32'(if_valid), 32'd0);
    check("ihs_wait", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBADC_0DE5;
    cyc();
    imem_resp_valid = 1'b0; #1;
    check("ihs_drop_valid", 32'(if_valid), 32'd0);
    check("ihs_drop_instr", if_instr, NOP);
    check("ihs_req_valid", 32'(imem_req_valid), 32'd1);

    // Flush and response in the same WAIT cycle; extra response in IDLE ignored.
    pc = 32'h200; imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; flush = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    cyc();
    flush = 1'b0; #1;
    check("same_if_valid", 32'(if_valid), 32'd0);
    check("same_req_valid", 32'(imem_req_valid), 32'd1);
    cyc();
    imem_resp_valid = 1'b0; #1;
    check("idle_resp_ign", 32'(if_valid), 32'd0);
    check("idle_resp_instr", if_instr, NOP);

    // Reset mid-WAIT abandons the request; late response ignored.
    fetch(32'h2FC, 32'h0000_0593);
    pc = 32'h300; imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; #2;
    reset = 1'b1; #1;
    check("arst_req_valid", 32'(imem_req_valid), 32'd1);
    check("arst_if_valid", 32'(if_valid), 32'd0);
    check("arst_if_instr", if_instr, NOP);
    @(negedge clk) reset = 1'b0;
    cyc();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_BABE;
    cyc();
    imem_resp_valid = 1'b0; #1;
    check("late_if_valid", 32'(if_valid), 32'd0);
    check("late_req_valid", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1; #1;
    check("post_rst_pc_stall", 32'(pc_stall), 32'd0);
    check("post_rst_req_addr", imem_req_addr, 32'h300);
    cyc();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0613;
    cyc();
    imem_resp_valid = 1'b0; #1;
    check("post_rst_if_valid", 32'(if_valid), 32'd1);
    check("post_rst_if_pc", if_pc, 32'h300);
    check("post_rst_if_instr", if_instr, 32'h0000_0613);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: NOP_INSTR, 32'h0000_0013, instruction word presented on if_instr when no valid instruction is held.
REQ-002 SHALL have port: clk  input  1  Clock; single clock, all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  Bool; asynchronous, active-high reset.
REQ-004 SHALL have port: pc  input  32  Addr; current program counter value.
REQ-005 SHALL have port: flush  input  1  Bool; redirect taken (same signal as PC jump enable), kills all in-flight and held fetches.
REQ-006 SHALL have port: decode_stall  input  1  Bool; decode cannot accept if_* this cycle.
REQ-007 SHALL have port: imem_req_valid  output  1  Bool; fetch request valid.
REQ-008 SHALL have port: imem_req_addr  output  32  Addr; fetch address, equal to pc.
REQ-009 SHALL have port: imem_req_ready  input  1  Bool; memory accepts request.
REQ-010 SHALL have port: imem_resp_valid  input  1  Bool; response word valid.
REQ-011 SHALL have port: imem_resp_data  input  32  Instr; response word.
REQ-012 SHALL have port: if_valid  output  1  Bool; IF/ID register holds a live instruction.
REQ-013 SHALL have port: if_pc  output  32  Addr; address of held instruction.
REQ-014 SHALL have port: if_instr  output  32  Instr; held instruction word.
REQ-015 SHALL have port: pc_stall  output  1  Bool; drives PC stall input.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, HOLD plus a drop flag; at most one outstanding request.
REQ-017 IDLE: imem_req_valid=1, imem_req_addr=pc; on handshake (valid&&ready) latch req_pc=pc, go WAIT; otherwise stay IDLE.
REQ-018 WAIT: imem_req_valid=0; on imem_resp_valid with drop=0: if !if_valid || !decode_stall, load if_pc=req_pc, if_instr=data, if_valid=1, go IDLE; else store word in one-entry buffer, go HOLD.
REQ-019 WAIT with drop=1: on imem_resp_valid discard word, clear drop, go IDLE.
REQ-020 HOLD: imem_req_valid=0; when !decode_stall move buffer to IF/ID register (if_valid=1), go IDLE.
REQ-021 When if_valid=1, !decode_stall and no new load occurs, SHALL clear if_valid at next edge.
REQ-022 pc_stall SHALL equal !(imem_req_valid && imem_req_ready); PC advances only on accepted request.
REQ-023 flush SHALL take priority over all other events: next edge if_valid=0, buffer discarded, HOLD->IDLE.
REQ-024 flush in WAIT (or coinciding with response in WAIT) SHALL set drop=1 unless the response arrives in the same cycle, in which case that response is discarded and state goes IDLE.
REQ-025 flush coinciding with an IDLE handshake SHALL go WAIT with drop=1 (stale address).
REQ-026 flush in IDLE without handshake SHALL stay IDLE; next request uses redirected pc.
REQ-027 imem_resp_valid outside WAIT SHALL be ignored.
REQ-028 if_instr SHALL read NOP_INSTR whenever if_valid=0.
REQ-029 Minimum latency: request accepted cycle N, response N+1, if_valid visible after edge N+1; peak throughput one instruction per 2 cycles.

Reset
REQ-030 reset SHALL asynchronously force state=IDLE, drop=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR, buffer cleared.
REQ-031 Reset mid-WAIT SHALL abandon the outstanding request; a late response after reset release arrives in IDLE and is ignored.

Structure
REQ-032 Addr, Instr, Bool, Clock typedefs and NOP encoding constant SHALL live in the shared package; FSM state enum local to module.
REQ-033 The IF/ID output register SHALL be a sub-module if_id_register (load, clear, hold).

Verification
REQ-034 Reset, pc=0, ready=1, response 1 cycle later data=32'h00500093 -> if_valid=1, if_pc=0, if_instr=32'h00500093; pc_stall=0 only in handshake cycle.
REQ-035 imem_req_ready low 3 cycles -> pc_stall=1 all 3 cycles, req_addr stable, no if_valid.
REQ-036 decode_stall=1 with if_valid=1 and new response 32'h00A00113 -> state HOLD, if_* unchanged; drop decode_stall -> if_instr=32'h00A00113 next edge.
REQ-037 flush in WAIT, response 32'hDEADBEEF arrives 2 cycles later -> never on if_*; next request uses redirected pc=32'h100.
REQ-038 flush same cycle as IDLE handshake -> returning word dropped, if_valid stays 0.
REQ-039 reset asserted mid-WAIT, response arrives after release -> if_valid=0, state IDLE, new request issued.
